sprite_list_writer: RTL

- Avalon-MM slave on the HPS/CPU side that assembles the 20-entry sprite descriptor list consumed by the VGA display block.
- Software writes descriptors into a shadow buffer, then requests a commit. The block copies shadow to the live list only at the start of vertical sync, then pulses gl_write, so the display never sees a torn list.
- Sits between the Avalon bus and the display block's gl_input/write inputs.

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/vsync_edge_sync.sv | 17 +
 rtl/sprite_list_writer.sv | 99 +++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite descriptor list writer.
package sprite_pkg;
   localparam int N_ENTRIES = 20;
   localparam int ENTRY_W   = 24;
   localparam int LIST_W    = 512;

   typedef struct packed {
      logic [4:0] id;
      logic [9:0] x;
      logic [8:0] y;
   } sprite_desc_t;

   localparam logic [4:0] ADDR_FRAME  = 5'd28;
   localparam logic [4:0] ADDR_STATUS = 5'd29;
   localparam logic [4:0] ADDR_CLEAR  = 5'd30;
   localparam logic [4:0] ADDR_COMMIT = 5'd31;
   localparam logic [4:0] ADDR_LAST_ENTRY = 5'(N_ENTRIES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      PUBLISH = 2'd2
   } state_e;
endpackage

// File: rtl/vsync_edge_sync.sv
// Brings VGA_VS into the system clock domain and flags the start of vertical sync.
module vsync_edge_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic vs_async_i,
   output logic vs_fall_o
);
   // [0],[1] are the synchroniser, [2] is the previous synchronised value
   logic [2:0] sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[1:0], vs_async_i};
   end

   assign vs_fall_o = sync_q[2] & ~sync_q[1];
endmodule

// File: rtl/sprite_list_writer.sv
// Avalon-MM shadow/live sprite list; commits are published only at vsync start.
module sprite_list_writer
   import sprite_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              chipselect,
   input  logic              write,
   input  logic              read,
   input  logic [4:0]        address,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic              vga_vs,
   output logic [LIST_W-1:0] gl_input,
   output logic              gl_write
);
   localparam int PAD_W = LIST_W - N_ENTRIES * ENTRY_W;

   sprite_desc_t [N_ENTRIES-1:0] shadow_q, shadow_d, live_q;
   state_e       state_q, state_d;
   logic [31:0]  readdata_q, readdata_d;
   logic [15:0]  frame_q;
   logic         gl_write_q;
   logic         vs_start;

   logic wr_en, rd_en, entry_sel, clear_req, commit_req;
   logic unused_wdata;

   assign wr_en      = chipselect & write;
   assign rd_en      = chipselect & read;
   assign entry_sel  = (address <= ADDR_LAST_ENTRY);
   assign clear_req  = wr_en && (address == ADDR_CLEAR);
   assign commit_req = wr_en && (address == ADDR_COMMIT) && writedata[0];
   assign unused_wdata = ^writedata[31:ENTRY_W];

   vsync_edge_sync u_vs_sync (
      .clk        (clk),
      .reset_n    (reset_n),
      .vs_async_i (vga_vs),
      .vs_fall_o  (vs_start)
   );

   always_comb begin
      shadow_d = shadow_q;
      if (clear_req)
         shadow_d = '0;
      else if (wr_en && entry_sel)
         shadow_d[address] = sprite_desc_t'(writedata[ENTRY_W-1:0]);
   end

   // A commit landing on the vs_start edge only arms; publish waits for the next frame
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (commit_req) state_d = PENDING;
         PENDING: if (vs_start)   state_d = PUBLISH;
         PUBLISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      readdata_d = readdata_q;
      if (rd_en) begin
         readdata_d = '0;
         if (entry_sel)
            readdata_d = {{(32-ENTRY_W){1'b0}}, shadow_q[address]};
         else if (address == ADDR_FRAME)
            readdata_d = {16'h0, frame_q};
         else if (address == ADDR_STATUS)
            readdata_d = {30'h0, state_q == PUBLISH, state_q == PENDING};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow_q   <= '0;
         live_q     <= '0;
         state_q    <= IDLE;
         readdata_q <= '0;
         frame_q    <= '0;
         gl_write_q <= 1'b0;
      end else begin
         shadow_q   <= shadow_d;
         state_q    <= state_d;
         readdata_q <= readdata_d;
         gl_write_q <= (state_q == PUBLISH);
         if (vs_start)
            frame_q <= frame_q + 16'd1;
         // copy sees the pre-write shadow when a bus write shares this edge
         if (state_q == PUBLISH)
            live_q <= shadow_q;
      end
   end

   assign readdata = readdata_q;
   assign gl_write = gl_write_q;
   assign gl_input = {{PAD_W{1'b0}}, live_q};
endmodule
